baud_tick_generator: RTL and testbench
======================================

# baud_tick_generator

Multi-channel, parametrised baud-rate tick generator for the serial subsystem. Each channel runs from the single system clock and emits single-cycle clock-enable strobes: an oversample tick and a bit tick. No derived clocks are produced. Per-channel mode and divisor are written at runtime. A per-channel resync input aligns the bit tick to mid-bit for receivers.

## Interface
- CHANNELS, 2: number of independent tick channels (≥1)
- DIV_WIDTH, 16: divisor width (≥8)
- OVERSAMPLE, 16: oversample ticks per bit tick (power of two, ≥2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  config write strobe
- cfg_ch  in  clog2(CHANNELS) (min 1)  target channel
- cfg_mode  in  2  0=off, 1=bypass, 2=pow2, 3=linear
- cfg_div  in  DIV_WIDTH  divisor; in pow2 mode only [2:0] is used
- sync  in  CHANNELS  per-channel resync pulse
- os_tick  out  CHANNELS  oversample strobe, registered
- bit_tick  out  CHANNELS  bit strobe, registered, always coincident with an os_tick
- active  out  CHANNELS  channel mode ≠ off

## Operation
- Per-channel state: mode (2 b), reload (DIV_WIDTH), cnt (DIV_WIDTH), os_cnt (clog2(OVERSAMPLE)).
- Reload computed at write time:
  - linear: reload = cfg_div.
  - pow2: reload = 2^(cfg_div[2:0]+1) − 1, giving a period of 2..256 cycles.
  - bypass/off: reload = 0.
- Active channel, each clk:
  - if cnt==0: cnt←reload and os_tick←1;
  - else: cnt←cnt−1 and os_tick←0.
  - Resulting os_tick period = reload+1 cycles. In bypass, os_tick is high every cycle.
- On each generated os_tick:
  - if os_cnt==OVERSAMPLE−1: bit_tick←1 and os_cnt←0;
  - else: os_cnt←os_cnt+1 and bit_tick←0.
- Off mode: cnt, os_cnt held at 0; os_tick, bit_tick, active all 0.
- Config write (cfg_we, cfg_ch<CHANNELS):
  - mode and reload updated.
  - cnt←new reload, os_cnt←0, both ticks←0 on that edge.
- Config write with cfg_ch≥CHANNELS: ignored, no state change.
- sync[i] on an active channel:
  - cnt←reload, os_cnt←OVERSAMPLE/2, ticks←0.
  - The next bit_tick falls on the OVERSAMPLE/2-th following os_tick, which is mid-bit.
- sync on an off channel: ignored.
- Simultaneous cfg write and sync to the same channel: the cfg write wins and sync is dropped.
- sync to other channels in the same cycle acts normally.
- Channels are fully independent. There is no shared counter and no cross-channel phase relation.

## Timing
- Reset values:
  - All outputs 0; all channels off.
  - reload, cnt, os_cnt = 0.
- Reset is asynchronous assert. Deassertion is applied as-is; the synchroniser lives outside this block.
- Reset mid-operation: ticks drop immediately; channels return to off.
- Latency, cfg write at edge E with reload R:
  - First os_tick is high in the cycle after edge E+R+1.
  - Bypass (R=0): first os_tick in the cycle after E+1.
- Latency, sync at edge E: same first-os_tick latency as a config write.
- Steady state:
  - bit_tick period = (R+1)·OVERSAMPLE cycles.
  - Duty of each strobe: exactly one clk.
- Mode change mid-bit truncates the current bit. No glitch: there is never a double tick within a single cycle.

## Structure
- Shared package serial_pkg:
  - mode encoding constants MODE_OFF/BYPASS/POW2/LINEAR.
  - Reload-compute function.
- Sub-module baud_tick_channel: one channel's state and logic; ports clk, reset, wr, mode, div, sync, os_tick, bit_tick, active.
- Top level: cfg_ch decode into per-channel wr, plus a generate loop instantiating CHANNELS × baud_tick_channel.

## Test plan
- Reset released, no writes → all outputs 0 for 1000 cycles.
- Ch0 linear, div=3, OVERSAMPLE=16:
  - os_tick every 4 cycles; first os_tick 4 cycles after the write edge.
  - bit_tick every 64 cycles, coincident with the 16th os_tick.
- Ch1 pow2, div[2:0]=0..7 in turn → os_tick period 2, 4, …, 256. Ch1 bypass → os_tick every cycle, bit_tick every 16 cycles.
- Ch0 linear div=9, sync pulsed mid-bit:
  - next bit_tick after exactly 8 os_ticks (80 cycles).
  - sync in the same cycle as a ch0 cfg write → os_cnt=0, so the next bit_tick comes after 16 os_ticks.
- cfg_ch=CHANNELS (out of range) write → no channel state changes. Write off to ch0 mid-run → ticks and active 0 the next cycle; ch1 is unaffected.
- Reset asserted asynchronously mid-period → outputs 0 before the next clk edge. After release, the channel stays off until rewritten.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial subsystem: channel mode encoding and the
// divisor-to-reload mapping used by the baud tick channels.
package serial_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BYPASS = 2'd1,
    MODE_POW2   = 2'd2,
    MODE_LINEAR = 2'd3
  } mode_e;

  // Reload value for a channel; the os_tick period is reload + 1 cycles.
  // pow2 uses only div[2:0], giving periods of 2..256 cycles.
  function automatic logic [31:0] reload_calc(mode_e mode, logic [31:0] div);
    logic [31:0] r;
    r = '0;
    case (mode)
      MODE_LINEAR: r = div;
      MODE_POW2:   r = (32'd2 << div[2:0]) - 32'd1;
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/baud_tick_generator_if.sv
// Configuration, resync and strobe bundle between the serial subsystem and the
// baud tick generator.
interface baud_tick_generator_if #(
  parameter int CHANNELS  = 2,
  parameter int DIV_WIDTH = 16
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [1:0]           cfg_mode;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [CHANNELS-1:0]  sync;
  logic [CHANNELS-1:0]  os_tick;
  logic [CHANNELS-1:0]  bit_tick;
  logic [CHANNELS-1:0]  active;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_div, sync,
    input  os_tick, bit_tick, active
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_mode, cfg_div, sync,
    output os_tick, bit_tick, active
  );

endinterface

// File: rtl/baud_tick_channel.sv
// One baud tick channel: a reload down-counter producing the oversample strobe
// and an oversample counter producing the bit strobe, both as clock enables.
module baud_tick_channel
  import serial_pkg::*;
#(
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  mode_e                mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 sync,
  output logic                 os_tick,
  output logic                 bit_tick,
  output logic                 active
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

  mode_e                cur_mode;
  logic [DIV_WIDTH-1:0] reload;
  logic [DIV_WIDTH-1:0] cnt;
  logic [OS_W-1:0]      os_cnt;
  logic [DIV_WIDTH-1:0] reload_nxt;

  assign reload_nxt = DIV_WIDTH'(reload_calc(mode, 32'(div)));
  assign active     = (cur_mode != MODE_OFF);

  // Priority: config write, then off-hold, then resync, then normal counting.
  // NOTE: all state is updated with non-blocking assignments so every branch
  // sees the pre-edge values of cnt/os_cnt regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_mode <= MODE_OFF;
      reload   <= '0;
      cnt      <= '0;
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (wr) begin
      cur_mode <= mode;
      reload   <= reload_nxt;
      cnt      <= reload_nxt;
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (cur_mode == MODE_OFF) begin
      cnt      <= '0;
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (sync) begin
      cnt      <= reload;
      os_cnt   <= OS_HALF;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt     <= reload;
      os_tick <= 1'b1;
      if (os_cnt == OS_LAST) begin
        os_cnt   <= '0;
        bit_tick <= 1'b1;
      end else begin
        os_cnt   <= os_cnt + OS_W'(1);
        bit_tick <= 1'b0;
      end
    end else begin
      cnt      <= cnt - DIV_WIDTH'(1);
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// Multi-channel baud tick generator: decodes config writes to a single channel
// and instantiates one independent baud_tick_channel per channel.
module baud_tick_generator
  import serial_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input logic                  clk,
  input logic                  reset,
  baud_tick_generator_if.slave bus
);

  logic [CHANNELS-1:0] wr;
  logic [CHANNELS-1:0] os_v;
  logic [CHANNELS-1:0] bit_v;
  logic [CHANNELS-1:0] act_v;

  // Out-of-range cfg_ch values match no channel, so such writes are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr[i] = bus.cfg_we && (32'(bus.cfg_ch) == 32'(i));

    baud_tick_channel #(
      .DIV_WIDTH (DIV_WIDTH),
      .OVERSAMPLE(OVERSAMPLE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[i]),
      .mode    (mode_e'(bus.cfg_mode)),
      .div     (bus.cfg_div),
      .sync    (bus.sync[i]),
      .os_tick (os_v[i]),
      .bit_tick(bit_v[i]),
      .active  (act_v[i])
    );
  end

  assign bus.os_tick  = os_v;
  assign bus.bit_tick = bit_v;
  assign bus.active   = act_v;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator: reset, linear/pow2/bypass periods,
// resync, config priority, out-of-range writes and asynchronous reset.
module tb_baud_tick_generator;
  import serial_pkg::*;

  localparam int CH = 3;
  localparam int DW = 16;
  localparam int OS = 16;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  baud_tick_generator_if #(.CHANNELS(CH), .DIV_WIDTH(DW)) bus ();

  baud_tick_generator #(
    .CHANNELS  (CH),
    .DIV_WIDTH (DW),
    .OVERSAMPLE(OS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Called on a negedge; returns on the negedge after the write edge.
  task automatic cfg_write(input int ch, input mode_e m, input int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CW'(ch);
    bus.cfg_mode = m;
    bus.cfg_div  = DW'(d);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_mode = '0;
    bus.cfg_div  = '0;
    bus.sync     = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.os_tick, bus.bit_tick, bus.active} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected 0", {bus.os_tick, bus.bit_tick, bus.active});
    end
    reset = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.os_tick, bus.bit_tick, bus.active} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: got %b expected 0", k,
                 {bus.os_tick, bus.bit_tick, bus.active});
      end
    end
  endtask

  task automatic test_linear();
    cfg_write(0, MODE_LINEAR, 3);
    n_checks++;
    if (bus.active !== 3'b001) begin
      n_fail++;
      $display("FAIL linear_active: got %b expected 001", bus.active);
    end
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.os_tick[0] !== ((k % 4) == 0)) begin
        n_fail++;
        $display("FAIL linear_os k=%0d: got %b expected %b", k, bus.os_tick[0], (k % 4) == 0);
      end
      n_checks++;
      if (bus.bit_tick[0] !== ((k % 64) == 0)) begin
        n_fail++;
        $display("FAIL linear_bit k=%0d: got %b expected %b", k, bus.bit_tick[0], (k % 64) == 0);
      end
    end
    n_checks++;
    if (bus.os_tick[2:1] !== 2'b00) begin
      n_fail++;
      $display("FAIL linear_others: got %b expected 00", bus.os_tick[2:1]);
    end
  endtask

  task automatic test_pow2_bypass();
    for (int d = 0; d < 8; d++) begin
      int period;
      int first;
      int second;
      period = 2 << d;
      first  = 0;
      second = 0;
      // Upper divisor bits set to show only [2:0] matters in pow2 mode.
      cfg_write(1, MODE_POW2, d | 16'h0A50);
      for (int k = 1; k <= 300 && first == 0; k++) begin
        @(negedge clk);
        if (bus.os_tick[1]) first = k;
      end
      n_checks++;
      if (first != period) begin
        n_fail++;
        $display("FAIL pow2_first d=%0d: got %0d expected %0d", d, first, period);
      end
      for (int k = 1; k <= 300 && second == 0; k++) begin
        @(negedge clk);
        if (bus.os_tick[1]) second = k;
      end
      n_checks++;
      if (second != period) begin
        n_fail++;
        $display("FAIL pow2_period d=%0d: got %0d expected %0d", d, second, period);
      end
    end
    cfg_write(1, MODE_BYPASS, 7);
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.os_tick[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL bypass_os k=%0d: got %b expected 1", k, bus.os_tick[1]);
      end
      n_checks++;
      if (bus.bit_tick[1] !== ((k % 16) == 0)) begin
        n_fail++;
        $display("FAIL bypass_bit k=%0d: got %b expected %b", k, bus.bit_tick[1], (k % 16) == 0);
      end
    end
  endtask

  task automatic test_sync();
    int n_os0;
    int bit0_at;
    int bit1_at;
    cfg_write(0, MODE_LINEAR, 9);
    repeat (35) @(negedge clk);
    bus.sync = 3'b001;
    @(negedge clk);
    bus.sync = '0;
    n_checks++;
    if (bus.os_tick[0] !== 1'b0 || bus.bit_tick[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_clear: got %b%b expected 00", bus.os_tick[0], bus.bit_tick[0]);
    end
    n_os0   = 0;
    bit0_at = 0;
    for (int k = 1; k <= 200 && bit0_at == 0; k++) begin
      @(negedge clk);
      if (bus.os_tick[0]) n_os0++;
      if (bus.bit_tick[0]) bit0_at = k;
    end
    n_checks++;
    if (bit0_at != 80) begin
      n_fail++;
      $display("FAIL sync_bit_latency: got %0d expected 80", bit0_at);
    end
    n_checks++;
    if (n_os0 != 8) begin
      n_fail++;
      $display("FAIL sync_os_count: got %0d expected 8", n_os0);
    end

    // Write and sync on ch0 together (write wins), plain sync on ch1.
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CW'(0);
    bus.cfg_mode = MODE_LINEAR;
    bus.cfg_div  = DW'(9);
    bus.sync     = 3'b011;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
    bus.sync     = '0;
    n_checks++;
    if (bus.os_tick[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_ch1_clear: got %b expected 0", bus.os_tick[1]);
    end
    n_os0   = 0;
    bit0_at = 0;
    bit1_at = 0;
    for (int k = 1; k <= 400 && bit0_at == 0; k++) begin
      @(negedge clk);
      if (bus.os_tick[0]) n_os0++;
      if (bus.bit_tick[0]) bit0_at = k;
      if (bus.bit_tick[1] && bit1_at == 0) bit1_at = k;
    end
    n_checks++;
    if (bit0_at != 160) begin
      n_fail++;
      $display("FAIL cfg_beats_sync_latency: got %0d expected 160", bit0_at);
    end
    n_checks++;
    if (n_os0 != 16) begin
      n_fail++;
      $display("FAIL cfg_beats_sync_os: got %0d expected 16", n_os0);
    end
    n_checks++;
    if (bit1_at != 8) begin
      n_fail++;
      $display("FAIL sync_other_ch: got %0d expected 8", bit1_at);
    end
  endtask

  task automatic test_range_and_off();
    cfg_write(0, MODE_LINEAR, 3);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.os_tick[0] !== ((k % 4) == 0) || bus.bit_tick[0] !== ((k % 64) == 0)) begin
        n_fail++;
        $display("FAIL oor_ch0 k=%0d: got %b%b expected %b%b", k, bus.os_tick[0],
                 bus.bit_tick[0], (k % 4) == 0, (k % 64) == 0);
      end
      if (k == 6) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = CW'(CH);
        bus.cfg_mode = MODE_OFF;
        bus.cfg_div  = '0;
      end else if (k == 7) begin
        bus.cfg_we = 1'b0;
      end
      if (k == 10) begin
        n_checks++;
        if (bus.active !== 3'b011) begin
          n_fail++;
          $display("FAIL oor_active: got %b expected 011", bus.active);
        end
      end
    end
    cfg_write(0, MODE_OFF, 3);
    n_checks++;
    if ({bus.os_tick[0], bus.bit_tick[0], bus.active[0]} !== 3'b000) begin
      n_fail++;
      $display("FAIL off_ch0: got %b expected 000",
               {bus.os_tick[0], bus.bit_tick[0], bus.active[0]});
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.os_tick[0] !== 1'b0 || bus.os_tick[1] !== 1'b1 || bus.active !== 3'b010) begin
        n_fail++;
        $display("FAIL off_hold k=%0d: got os=%b act=%b expected os=x10 act=010", k,
                 bus.os_tick, bus.active);
      end
    end
  endtask

  task automatic test_async_reset();
    cfg_write(0, MODE_LINEAR, 9);
    repeat (23) @(negedge clk);
    n_checks++;
    if (bus.os_tick[1] !== 1'b1 || bus.active !== 3'b011) begin
      n_fail++;
      $display("FAIL pre_reset: got os=%b act=%b expected os=x1x act=011", bus.os_tick, bus.active);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.os_tick, bus.bit_tick, bus.active} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 0", {bus.os_tick, bus.bit_tick, bus.active});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.os_tick, bus.bit_tick, bus.active} !== '0) begin
        n_fail++;
        $display("FAIL post_reset k=%0d: got %b expected 0", k,
                 {bus.os_tick, bus.bit_tick, bus.active});
      end
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_pow2_bypass();
    test_sync();
    test_range_and_off();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
